// File: rtl/mmio_pkg.sv
// Shared definitions for memory-mapped peripherals: register offsets, STATUS layout
// and the UART transmitter state encoding.
package mmio_pkg;

  localparam logic DATA_OFFSET   = 1'b0;
  localparam logic STATUS_OFFSET = 1'b1;

  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_EMPTY_BIT = 2;
  localparam int unsigned STATUS_OVF_BIT   = 3;
  localparam int unsigned STATUS_CNT_LSB   = 4;
  localparam int unsigned STATUS_CNT_W     = 4;

  typedef struct packed {
    logic [23:0] reserved;
    logic [3:0]  count;
    logic        overflow;
    logic        empty;
    logic        full;
    logic        busy;
  } uart_status_t;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO; pointers wrap mod DEPTH, a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA pushes bytes into a TX FIFO, STATUS reports
// FIFO/FSM state and a sticky overflow flag; reads are registered one cycle after address.
module uart_tx_mmio
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFE0,
  parameter logic [31:0] TOP_MEMORY   = 32'hFFFF_FFE7,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWrite,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  output logic        tx
);

  localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  logic               hit;
  logic               offset;
  logic               push_req;
  logic               clr_req;
  logic               pop;
  logic [7:0]         fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [31:0]        count_wide;
  logic               overflow;
  uart_status_t       status;

  uart_tx_state_t     state;
  uart_tx_state_t     next_state;
  logic [TIMER_W-1:0] bit_timer;
  logic [TIMER_W-1:0] bit_timer_d;
  logic [2:0]         bit_idx;
  logic [2:0]         bit_idx_d;
  logic [7:0]         shift;
  logic [7:0]         shift_d;
  logic               tx_d;
  logic               timer_done;
  logic               unused_bits;

  assign hit      = (memAddress >= BASE_MEMORY) && (memAddress <= TOP_MEMORY);
  assign offset   = memAddress[2];
  assign push_req = memWrite && hit && (offset == DATA_OFFSET) && byteMask[0];
  assign clr_req  = memWrite && hit && (offset == STATUS_OFFSET) && byteMask[0]
                    && memWriteData[STATUS_OVF_BIT];
  assign pop      = (state == UART_IDLE) && !fifo_empty;
  assign timer_done = (bit_timer == TIMER_LAST);
  assign unused_bits = &{1'b0, memWriteData[31:8], byteMask[3:1]};

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .pop     (pop),
    .wdata   (memWriteData[7:0]),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky overflow: a dropped byte wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_req) begin
      overflow <= 1'b0;
    end
  end

  assign count_wide = 32'(fifo_count);

  always_comb begin
    status          = '0;
    status.busy     = (state != UART_IDLE);
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.overflow = overflow;
    status.count    = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memReadData <= '0;
    end else if (hit && (offset == STATUS_OFFSET)) begin
      memReadData <= status;
    end else begin
      memReadData <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= UART_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      UART_IDLE:  if (!fifo_empty) next_state = UART_START;
      UART_START: if (timer_done)  next_state = UART_DATA;
      UART_DATA:  if (timer_done && (bit_idx == 3'd7)) next_state = UART_STOP;
      UART_STOP:  if (timer_done)  next_state = UART_IDLE;
      default:    next_state = UART_IDLE;
    endcase
  end

  // tx is derived from the next state so the line changes on the same edge as the state.
  always_comb begin
    shift_d     = shift;
    bit_timer_d = '0;
    bit_idx_d   = '0;
    tx_d        = 1'b1;
    if (pop) shift_d = fifo_head;
    if (state != UART_IDLE) bit_timer_d = timer_done ? '0 : bit_timer + TIMER_W'(1);
    if (state == UART_DATA) begin
      bit_idx_d = timer_done ? bit_idx + 3'd1 : bit_idx;
      if (timer_done) shift_d = {1'b0, shift[7:1]};
    end
    case (next_state)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx        <= 1'b1;
      shift     <= '0;
      bit_timer <= '0;
      bit_idx   <= '0;
    end else begin
      tx        <= tx_d;
      shift     <= shift_d;
      bit_timer <= bit_timer_d;
      bit_idx   <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stored bytes are queued as expected frames and a
// line monitor compares every 40-cycle frame cycle-by-cycle against the queued byte.
module tb_uart_tx_mmio;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] DATA_ADDR   = 32'hFFFF_FFE0;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFE4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  bit mon_en = 1'b0;
  bit in_frame = 1'b0;

  uart_tx_mmio #(
    .BASE_MEMORY  (32'hFFFF_FFE0),
    .TOP_MEMORY   (32'hFFFF_FFE7),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .byteMask     (byteMask),
    .memReadData  (memReadData),
    .tx           (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Line monitor: captures each frame, aborts on reset, checks against the scoreboard.
  initial begin
    logic [39:0] wave;
    logic [39:0] exp_wave;
    logic [7:0]  exp_byte;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        in_frame = 1'b1;
        starts.push_back(cyc);
        aborted = 1'b0;
        wave = '0;
        for (int k = 0; k < 40; k++) begin
          if (k > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          wave[k] = tx;
        end
        if (!aborted) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got wave %h, required no frame", wave);
          end else begin
            exp_byte = exp_q.pop_front();
            for (int k = 0; k < 40; k++) begin
              if (k < 4)       exp_wave[k] = 1'b0;
              else if (k < 36) exp_wave[k] = exp_byte[(k - 4) / 4];
              else             exp_wave[k] = 1'b1;
            end
            if (wave !== exp_wave) begin
              errors++;
              $display("FAIL frame_wave: got %h, required %h (byte %h)", wave, exp_wave, exp_byte);
            end
          end
        end
        in_frame = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    memAddress = addr;
    memWriteData = data;
    byteMask = mask;
    memWrite = 1'b1;
    @(negedge clk);
    memWrite = 1'b0;
    byteMask = 4'h0;
    memAddress = 32'h0;
    memWriteData = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    memAddress = addr;
    memWrite = 1'b0;
    @(negedge clk);
    data = memReadData;
    memAddress = 32'h0;
  endtask

  task automatic wait_drain(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    memAddress = 32'h0;
    memWriteData = 32'h0;
    memWrite = 1'b0;
    byteMask = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    checks++;
    if (memReadData !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", memReadData); end
    reset = 1'b0;
    mon_en = 1'b1;
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h, required 00000004", rd); end
    bus_read(DATA_ADDR, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL data_read_zero: got %h, required 0", rd); end
    bus_read(32'hFFFF_FFE7, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin errors++; $display("FAIL top_addr_status: got %h, required 00000004", rd); end
    bus_read(32'hFFFF_FFE8, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL above_window: got %h, required 0", rd); end
    bus_read(32'hFFFF_FFDC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL below_window: got %h, required 0", rd); end
  endtask

  task automatic test_single();
    bit ok;
    starts.delete();
    exp_q.push_back(8'hA5);
    bus_write(DATA_ADDR, 32'hDEAD_BEA5, 4'b0001);
    wait_drain(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain: got timeout, required frame done"); end
    checks++;
    if (starts.size() != 1) begin errors++; $display("FAIL single_frames: got %0d, required 1", starts.size()); end
  endtask

  task automatic test_decode();
    bit ok;
    int n;
    n = starts.size();
    bus_write(DATA_ADDR, 32'h0000_005A, 4'b1110);
    bus_write(32'hFFFF_FFE8, 32'h0000_005A, 4'b0001);
    bus_write(32'hFFFF_FFDC, 32'h0000_005A, 4'b0001);
    repeat (60) @(negedge clk);
    checks++;
    if (starts.size() != n) begin errors++; $display("FAIL ignored_stores: got %0d frames, required %0d", starts.size(), n); end
    exp_q.push_back(8'h3C);
    bus_write(32'hFFFF_FFE3, 32'h0000_003C, 4'b0001);
    wait_drain(200, ok);
    checks++;
    if (!ok || starts.size() != n + 1) begin
      errors++;
      $display("FAIL unaligned_store: got %0d frames, required %0d", starts.size(), n + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bit ok;
    starts.delete();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h81);
    bus_write(DATA_ADDR, 32'h3C, 4'b0001);
    bus_write(DATA_ADDR, 32'hF0, 4'b0001);
    bus_write(DATA_ADDR, 32'h81, 4'b0001);
    repeat (20) @(negedge clk);
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_0021) begin errors++; $display("FAIL b2b_status1: got %h, required 00000021", rd); end
    repeat (39) @(negedge clk);
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_0011) begin errors++; $display("FAIL b2b_status2: got %h, required 00000011", rd); end
    repeat (39) @(negedge clk);
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_0005) begin errors++; $display("FAIL b2b_status3: got %h, required 00000005", rd); end
    wait_drain(200, ok);
    checks++;
    if (!ok || starts.size() != 3) begin
      errors++;
      $display("FAIL b2b_frames: got %0d, required 3", starts.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (starts[i + 1] - starts[i] != 41) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d cycles, required 41", i, starts[i + 1] - starts[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    starts.delete();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h66);
    bus_write(DATA_ADDR, 32'h11, 4'b0001);
    bus_write(DATA_ADDR, 32'h22, 4'b0001);
    bus_write(DATA_ADDR, 32'h33, 4'b0001);
    bus_write(DATA_ADDR, 32'h44, 4'b0001);
    bus_write(DATA_ADDR, 32'h66, 4'b0001);
    bus_write(DATA_ADDR, 32'h55, 4'b0001);
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_004B) begin errors++; $display("FAIL overflow_status: got %h, required 0000004B", rd); end
  endtask

  // Runs straight after test_overflow; relies on the first frame ending 36 cycles later.
  task automatic test_clear_overflow();
    logic [31:0] rd;
    bus_write(STATUS_ADDR, 32'h0000_0008, 4'b1110);
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_004B) begin errors++; $display("FAIL clear_masked: got %h, required 0000004B", rd); end
    bus_write(STATUS_ADDR, 32'h0000_0008, 4'b0001);
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_0043) begin errors++; $display("FAIL clear_overflow: got %h, required 00000043", rd); end
  endtask

  task automatic test_push_on_pop();
    logic [31:0] rd;
    bit ok;
    repeat (31) @(negedge clk);
    exp_q.push_back(8'h77);
    bus_write(DATA_ADDR, 32'h77, 4'b0001);
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_0043) begin errors++; $display("FAIL push_on_pop: got %h, required 00000043", rd); end
    wait_drain(400, ok);
    checks++;
    if (!ok || starts.size() != 6) begin
      errors++;
      $display("FAIL overflow_frames: got %0d, required 6", starts.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int n;
    starts.delete();
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h99);
    bus_write(DATA_ADDR, 32'hC3, 4'b0001);
    bus_write(DATA_ADDR, 32'h99, 4'b0001);
    repeat (17) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b, required 0", tx); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_abort_tx: got %b, required 1", tx); end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    n = starts.size();
    repeat (100) @(negedge clk);
    checks++;
    if (starts.size() != n || tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_frames: got %0d frames tx %b, required %0d tx 1", starts.size(), tx, n);
    end
    bus_read(STATUS_ADDR, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin errors++; $display("FAIL reset_abort_status: got %h, required 00000004", rd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_decode();
    test_back_to_back();
    test_overflow();
    test_clear_overflow();
    test_push_on_pop();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
